// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: control and output bundle for the clock-enable divider bank
interface clk_div_bank_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 24,
  parameter int CH_W  = 1
);
  logic [N_CH-1:0]  ch_en;
  logic             sync_clr;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_data;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  modport master (output ch_en, sync_clr, wr_en, wr_ch, wr_data, input clk_out, tick);
  modport slave  (input ch_en, sync_clr, wr_en, wr_ch, wr_data, output clk_out, tick);
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of programmable 50% duty clock-enable dividers with rising-edge strobes
module clk_div_bank #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 24,
  parameter int CH_W  = 1,
  parameter logic [N_CH*CNT_W-1:0] INIT_DIV = {24'd12499999, 24'd1}
)(
  input logic           CLK_NX,
  input logic           reset_n,
  clk_div_bank_if.slave bus
);
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] div_q [N_CH];
  logic [CNT_W-1:0] div_d [N_CH];
  logic [N_CH-1:0]  out_q, out_d, tick_q, tick_d;
  logic [N_CH-1:0]  hit, run, wrap;
  assign bus.clk_out = out_q;
  assign bus.tick    = tick_q;
  // Next state: sync_clr, a write or a disable clears the channel; a write still loads div under sync_clr
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      hit[i]    = bus.wr_en && bus.wr_ch == CH_W'(i);
      run[i]    = bus.ch_en[i] && !bus.sync_clr && !hit[i];
      wrap[i]   = cnt_q[i] >= div_q[i];
      div_d[i]  = hit[i] ? bus.wr_data : div_q[i];
      cnt_d[i]  = run[i] && !wrap[i] ? cnt_q[i] + CNT_W'(1) : '0;
      out_d[i]  = run[i] && (out_q[i] ^ wrap[i]);
      tick_d[i] = run[i] && wrap[i] && !out_q[i];
    end
  end
  // State registers; reset restores the INIT_DIV divisors with every output low
  always_ff @(posedge CLK_NX or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= INIT_DIV[i*CNT_W +: CNT_W];
      end
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed plus randomized checks of the divider bank against an arithmetic phase model
module tb_clk_div_bank;
  localparam int CW = 24;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  clk_div_bank_if #(.N_CH(2), .CNT_W(CW), .CH_W(1)) bus ();
  clk_div_bank_if #(.N_CH(1), .CNT_W(4), .CH_W(1)) bus2 ();
  clk_div_bank #(.N_CH(2), .CNT_W(CW), .CH_W(1), .INIT_DIV({24'd100, 24'd1})) dut (
    .CLK_NX(clk), .reset_n(reset_n), .bus(bus));
  clk_div_bank #(.N_CH(1), .CNT_W(4), .CH_W(1), .INIT_DIV(4'd15)) dut2 (
    .CLK_NX(clk), .reset_n(reset_n), .bus(bus2));
  // Model: k = enabled edges since the channel last restarted, d = divisor in force
  int k [2];
  int d [2];
  int k2, d2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k[0] <= 0; k[1] <= 0; d[0] <= 1; d[1] <= 100;
      k2 <= 0; d2 <= 15;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.wr_en && int'(bus.wr_ch) == i) d[i] <= int'(bus.wr_data);
        if (bus.sync_clr || !bus.ch_en[i] || (bus.wr_en && int'(bus.wr_ch) == i)) k[i] <= 0;
        else k[i] <= k[i] + 1;
      end
      if (bus2.wr_en && bus2.wr_ch == 1'b0) d2 <= int'(bus2.wr_data);
      if (bus2.sync_clr || !bus2.ch_en[0] || (bus2.wr_en && bus2.wr_ch == 1'b0)) k2 <= 0;
      else k2 <= k2 + 1;
    end
  end
  // High phase is the odd-numbered block of d+1 edges; tick marks its first edge
  function automatic logic exp_out(int kk, int dd);
    return ((kk / (dd + 1)) % 2) == 1;
  endfunction
  function automatic logic exp_tick(int kk, int dd);
    return kk > 0 && (kk % (dd + 1)) == 0 && ((kk / (dd + 1)) % 2) == 1;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("clk_out[%0d]", i), 32'(bus.clk_out[i]), 32'(exp_out(k[i], d[i])));
      chk($sformatf("tick[%0d]", i), 32'(bus.tick[i]), 32'(exp_tick(k[i], d[i])));
    end
    chk("w4_clk_out", 32'(bus2.clk_out[0]), 32'(exp_out(k2, d2)));
    chk("w4_tick", 32'(bus2.tick[0]), 32'(exp_tick(k2, d2)));
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask
  task automatic wr(int ch, int data);
    bus.wr_en = 1'b1; bus.wr_ch = 1'(ch); bus.wr_data = CW'(data);
    step(1);
    bus.wr_en = 1'b0;
  endtask
  initial begin
    int n;
    bus.ch_en = '0; bus.sync_clr = 0; bus.wr_en = 0; bus.wr_ch = '0; bus.wr_data = '0;
    bus2.ch_en = '0; bus2.sync_clr = 0; bus2.wr_en = 0; bus2.wr_ch = '0; bus2.wr_data = '0;
    #2 reset_n = 1'b0;
    #1 chk("reset_clk_out", 32'(bus.clk_out), 32'd0);
    chk("reset_tick", 32'(bus.tick), 32'd0);
    check_all();
    bus.ch_en = 2'b11; bus2.ch_en = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(60);
    wr(1, 10);
    step(10);
    chk("ch1_low_before_rise", 32'(bus.clk_out[1]), 32'd0);
    step(1);
    chk("ch1_first_rise", 32'(bus.clk_out[1]), 32'd1);
    chk("ch1_first_tick", 32'(bus.tick[1]), 32'd1);
    wr(0, 0);
    step(8);
    n = 0;
    while (bus.clk_out[0] !== 1'b1 && n < 4) begin step(1); n++; end
    chk("ch0_high_seen", 32'(bus.clk_out[0]), 32'd1);
    wr(0, 3);
    chk("ch0_cleared_by_write", 32'(bus.clk_out[0]), 32'd0);
    step(20);
    bus.ch_en = 2'b10;
    step(1);
    chk("ch0_disabled", 32'(bus.clk_out[0]), 32'd0);
    step(3);
    bus.ch_en = 2'b11;
    step(12);
    wr(0, 2);
    step(5);
    bus.sync_clr = 1'b1; bus.wr_en = 1'b1; bus.wr_ch = 1'b1; bus.wr_data = CW'(2);
    step(1);
    bus.sync_clr = 1'b0; bus.wr_en = 1'b0;
    chk("sync_all_low", 32'(bus.clk_out), 32'd0);
    step(2);
    chk("sync_still_low", 32'(bus.clk_out), 32'd0);
    step(1);
    chk("sync_rise_together", 32'(bus.clk_out), 32'd3);
    chk("sync_tick_together", 32'(bus.tick), 32'd3);
    bus2.wr_en = 1'b1; bus2.wr_ch = 1'b1; bus2.wr_data = 4'd3;
    step(1);
    bus2.wr_en = 1'b0;
    step(40);
    for (int it = 0; it < 400; it++) begin
      bus.ch_en = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
      bus2.ch_en = ($urandom_range(0, 9) == 0) ? 1'($urandom) : 1'b1;
      bus.sync_clr = ($urandom_range(0, 29) == 0);
      bus2.sync_clr = ($urandom_range(0, 29) == 0);
      bus.wr_en = ($urandom_range(0, 14) == 0);
      bus.wr_ch = 1'($urandom);
      bus.wr_data = CW'($urandom_range(0, 12));
      bus2.wr_en = ($urandom_range(0, 14) == 0);
      bus2.wr_ch = 1'($urandom);
      bus2.wr_data = 4'($urandom_range(0, 15));
      step(1);
    end
    bus.ch_en = 2'b11; bus2.ch_en = 1'b1;
    bus.sync_clr = 0; bus2.sync_clr = 0; bus.wr_en = 0; bus2.wr_en = 0;
    step(30);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(bus.clk_out), 32'd0);
    chk("async_reset_ticks", 32'(bus.tick), 32'd0);
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    step(1);
    chk("restored_div_rise", 32'(bus.clk_out[0]), 32'd1);
    step(70);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
